// File: rtl/bpf_core_sched_if.sv
// Dispatch, core-control and verdict signals of the BPF core scheduler.
// The scheduler connects through master; the filler, cores and forwarder use slave.
interface bpf_core_sched_if #(
  parameter int N_CORES                = 4,
  parameter int IDX_W                  = 2,
  parameter int PACKET_BYTE_ADDR_WIDTH = 12
);
  localparam int LEN_W = PACKET_BYTE_ADDR_WIDTH + 1;

  logic                     pkt_valid;
  logic [LEN_W-1:0]         pkt_len;
  logic                     pkt_ready;
  logic [IDX_W-1:0]         pkt_core;
  logic [N_CORES-1:0]       core_start;
  logic [N_CORES*LEN_W-1:0] core_len;
  logic [N_CORES-1:0]       core_acc;
  logic [N_CORES-1:0]       core_rej;
  logic [N_CORES-1:0]       core_abort;
  logic                     verdict_valid;
  logic                     verdict_ready;
  logic                     verdict_acc;
  logic                     verdict_timeout;
  logic [IDX_W-1:0]         verdict_core;
  logic [LEN_W-1:0]         verdict_len;

  modport master (
    input  pkt_valid, pkt_len, core_acc, core_rej, verdict_ready,
    output pkt_ready, pkt_core, core_start, core_len, core_abort,
           verdict_valid, verdict_acc, verdict_timeout, verdict_core, verdict_len
  );

  modport slave (
    output pkt_valid, pkt_len, core_acc, core_rej, verdict_ready,
    input  pkt_ready, pkt_core, core_start, core_len, core_abort,
           verdict_valid, verdict_acc, verdict_timeout, verdict_core, verdict_len
  );
endinterface

// File: rtl/bpf_core_sched.sv
// Round-robin packet dispatcher for N BPF cores with per-core watchdog and
// in-order verdict release; a core is freed only when its verdict is consumed.
module bpf_core_sched #(
  parameter int N_CORES                = 4,
  parameter int IDX_W                  = 2,
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int TIMEOUT_W              = 16,
  parameter int TIMEOUT_CYCLES         = 4096
) (
  input  logic               clk,
  input  logic               rst,
  bpf_core_sched_if.master   bus
);
  localparam int LEN_W = PACKET_BYTE_ADDR_WIDTH + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q [N_CORES];
  logic [LEN_W-1:0]     len_q   [N_CORES];
  logic [TIMEOUT_W-1:0] wd_q    [N_CORES];
  logic [IDX_W-1:0]     fifo_q  [N_CORES];
  logic [N_CORES-1:0]   acc_q, to_q, start_q, abort_q;
  logic [IDX_W-1:0]     rr_q, head_q, tail_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [IDX_W-1:0]     grant;
  logic                 any_idle;
  int unsigned          scan_idx;
  logic                 pkt_ready;
  logic                 verdict_valid;
  logic                 dispatch, pop;
  logic [IDX_W-1:0]     head_core;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_CORES - 1)) ? '0 : v + 1'b1;
  endfunction

  // First IDLE core at or after rr_q, wrapping modulo N_CORES.
  always_comb begin
    grant    = '0;
    any_idle = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      scan_idx = 32'(rr_q) + k;
      if (scan_idx >= N_CORES) scan_idx = scan_idx - N_CORES;
      if (!any_idle && state_q[IDX_W'(scan_idx)] == S_IDLE) begin
        any_idle = 1'b1;
        grant    = IDX_W'(scan_idx);
      end
    end
  end

  assign head_core     = fifo_q[head_q];
  assign pkt_ready     = rst & any_idle;
  assign verdict_valid = rst & (cnt_q != '0) & (state_q[head_core] == S_DONE);
  assign dispatch      = bus.pkt_valid & pkt_ready;
  assign pop           = verdict_valid & bus.verdict_ready;

  assign bus.pkt_ready       = pkt_ready;
  assign bus.pkt_core        = rst ? grant : '0;
  assign bus.core_start      = start_q;
  assign bus.core_abort      = abort_q;
  assign bus.verdict_valid   = verdict_valid;
  assign bus.verdict_acc     = acc_q[head_core];
  assign bus.verdict_timeout = to_q[head_core];
  assign bus.verdict_core    = head_core;
  assign bus.verdict_len     = len_q[head_core];

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_len
    assign bus.core_len[gi*LEN_W +: LEN_W] = len_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_CORES; i++) begin
        state_q[i] <= S_IDLE;
        len_q[i]   <= '0;
        wd_q[i]    <= '0;
        fifo_q[i]  <= '0;
      end
      acc_q   <= '0;
      to_q    <= '0;
      start_q <= '0;
      abort_q <= '0;
      rr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= '0;
      abort_q <= '0;
      // A verdict pulse in the expiry cycle wins over the watchdog.
      for (int unsigned i = 0; i < N_CORES; i++) begin
        if (state_q[i] == S_RUN) begin
          if (bus.core_acc[i] | bus.core_rej[i]) begin
            state_q[i] <= S_DONE;
            acc_q[i]   <= bus.core_acc[i] & ~bus.core_rej[i];
            to_q[i]    <= 1'b0;
          end else if (WD_EN && wd_q[i] == WD_LAST) begin
            state_q[i] <= S_DONE;
            acc_q[i]   <= 1'b0;
            to_q[i]    <= 1'b1;
            abort_q[i] <= 1'b1;
          end else if (wd_q[i] != WD_MAX) begin
            wd_q[i] <= wd_q[i] + 1'b1;
          end
        end
      end
      if (pop) begin
        state_q[head_core] <= S_IDLE;
        head_q             <= wrap_inc(head_q);
      end
      if (dispatch) begin
        state_q[grant] <= S_RUN;
        len_q[grant]   <= bus.pkt_len;
        wd_q[grant]    <= '0;
        acc_q[grant]   <= 1'b0;
        to_q[grant]    <= 1'b0;
        start_q[grant] <= 1'b1;
        fifo_q[tail_q] <= grant;
        tail_q         <= wrap_inc(tail_q);
        rr_q           <= wrap_inc(grant);
      end
      cnt_q <= cnt_q + CNT_W'(dispatch) - CNT_W'(pop);
    end
  end
endmodule
